// File: rtl/hsync_decoder.sv
// hsync_decoder: receive-side line-timing monitor for a horizontal sync stream.
// Samples hsync on PixelClock rising edges, recovers the line phase
// (sync, back porch, active, front porch), regenerates xposition and
// ActiveFlag, and checks every line against the programmed timing.
// Optional feature: define ERROR_COUNT_EN to add the saturating ErrorCount output.
module hsync_decoder #(
    parameter bit HSYNC_ACTIVE = 1'b0,
    parameter int LOCK_LINES   = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       PixelClock,
    input  logic       hsync,
    input  logic [9:0] SynchPulse,
    input  logic [9:0] BackPorch,
    input  logic [9:0] ActiveVideo,
    input  logic [9:0] FrontPorch,
    output logic [9:0] xposition,
    output logic       ActiveFlag,
    output logic       LineStart,
    output logic       Locked,
`ifdef ERROR_COUNT_EN
    output logic [7:0] ErrorCount,
`endif
    output logic       TimingError
);

    typedef enum logic [2:0] {HUNT, SYNC, BACK, ACTIVE, FRONT} state_t;

    localparam logic [3:0] LOCK_THRESH = 4'(LOCK_LINES);

    state_t     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [3:0] good_q, good_d;
    logic       pixelClockPrev_q;
    logic       prevAsserted_q, prevAsserted_d;
    logic [9:0] xposition_q, xposition_d;
    logic       activeFlag_q, activeFlag_d;
    logic       lineStart_q, lineStart_d;
    logic       locked_q, locked_d;
    logic       timingError_q, timingError_d;

    logic       tick;
    logic       asserted;
    logic [9:0] spEff, bpEff, avEff, fpEff;

    assign tick     = PixelClock & ~pixelClockPrev_q;
    assign asserted = (hsync == HSYNC_ACTIVE);

    // A zero in any timing field is treated as one tick
    assign spEff = (SynchPulse  == 10'd0) ? 10'd1 : SynchPulse;
    assign bpEff = (BackPorch   == 10'd0) ? 10'd1 : BackPorch;
    assign avEff = (ActiveVideo == 10'd0) ? 10'd1 : ActiveVideo;
    assign fpEff = (FrontPorch  == 10'd0) ? 10'd1 : FrontPorch;

    // Line-phase tracking: evaluate one pixel tick and decide the next phase and outputs
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        good_d         = good_q;
        prevAsserted_d = prevAsserted_q;
        xposition_d    = xposition_q;
        activeFlag_d   = activeFlag_q;
        lineStart_d    = 1'b0;
        timingError_d  = 1'b0;
        if (tick) begin
            prevAsserted_d = asserted;
            activeFlag_d   = 1'b0;
            xposition_d    = 10'd0;
            case (state_q)
                HUNT: begin
                    if (asserted && !prevAsserted_q) begin
                        state_d     = SYNC;
                        cnt_d       = 10'd1;
                        lineStart_d = 1'b1;
                    end
                end
                SYNC: begin
                    if (asserted) begin
                        if (cnt_q >= spEff) begin
                            timingError_d = 1'b1;
                            state_d       = HUNT;
                            cnt_d         = 10'd0;
                        end else begin
                            cnt_d = cnt_q + 10'd1;
                        end
                    end else if (cnt_q == spEff) begin
                        if (bpEff == 10'd1) begin
                            state_d = ACTIVE;
                            cnt_d   = 10'd0;
                        end else begin
                            state_d = BACK;
                            cnt_d   = 10'd1;
                        end
                    end else begin
                        timingError_d = 1'b1;
                        state_d       = HUNT;
                        cnt_d         = 10'd0;
                    end
                end
                BACK: begin
                    if (asserted) begin
                        timingError_d = 1'b1;
                        lineStart_d   = 1'b1;
                        state_d       = SYNC;
                        cnt_d         = 10'd1;
                    end else if (cnt_q >= bpEff - 10'd1) begin
                        state_d = ACTIVE;
                        cnt_d   = 10'd0;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
                ACTIVE: begin
                    if (asserted) begin
                        timingError_d = 1'b1;
                        lineStart_d   = 1'b1;
                        state_d       = SYNC;
                        cnt_d         = 10'd1;
                    end else begin
                        activeFlag_d = 1'b1;
                        xposition_d  = cnt_q;
                        if (cnt_q >= avEff - 10'd1) begin
                            state_d = FRONT;
                            cnt_d   = 10'd0;
                        end else begin
                            cnt_d = cnt_q + 10'd1;
                        end
                    end
                end
                FRONT: begin
                    if (cnt_q >= fpEff) begin
                        if (asserted) begin
                            lineStart_d = 1'b1;
                            state_d     = SYNC;
                            cnt_d       = 10'd1;
                            good_d      = (good_q == 4'd15) ? good_q : good_q + 4'd1;
                        end else begin
                            timingError_d = 1'b1;
                            state_d       = HUNT;
                            cnt_d         = 10'd0;
                        end
                    end else if (asserted) begin
                        timingError_d = 1'b1;
                        lineStart_d   = 1'b1;
                        state_d       = SYNC;
                        cnt_d         = 10'd1;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
                default: begin
                    state_d = HUNT;
                    cnt_d   = 10'd0;
                end
            endcase
            if (timingError_d) begin
                good_d = 4'd0;
            end
        end
        locked_d = (good_d >= LOCK_THRESH);
    end

    // State and output registers; PixelClockPrev resets high so a high PixelClock gives no tick
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= HUNT;
            cnt_q            <= 10'd0;
            good_q           <= 4'd0;
            pixelClockPrev_q <= 1'b1;
            prevAsserted_q   <= 1'b1;
            xposition_q      <= 10'd0;
            activeFlag_q     <= 1'b0;
            lineStart_q      <= 1'b0;
            locked_q         <= 1'b0;
            timingError_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            good_q           <= good_d;
            pixelClockPrev_q <= PixelClock;
            prevAsserted_q   <= prevAsserted_d;
            xposition_q      <= xposition_d;
            activeFlag_q     <= activeFlag_d;
            lineStart_q      <= lineStart_d;
            locked_q         <= locked_d;
            timingError_q    <= timingError_d;
        end
    end

`ifdef ERROR_COUNT_EN
    logic [7:0] errorCount_q;

    // Saturating count of timing violations, cleared only by reset
    always_ff @(posedge clock) begin
        if (reset) begin
            errorCount_q <= 8'd0;
        end else if (timingError_d && (errorCount_q != 8'hFF)) begin
            errorCount_q <= errorCount_q + 8'd1;
        end
    end

    assign ErrorCount = errorCount_q;
`endif

    assign xposition   = xposition_q;
    assign ActiveFlag  = activeFlag_q;
    assign LineStart   = lineStart_q;
    assign Locked      = locked_q;
    assign TimingError = timingError_q;

endmodule

// File: tb/tb_hsync_decoder.sv
// tb_hsync_decoder: randomized scoreboard bench for hsync_decoder.
// The reference model tracks the position of each tick within the line and
// derives the phase from the programmed boundaries. Define ERROR_COUNT_EN to
// also check ErrorCount.
`timescale 1ns/100ps
module tb_hsync_decoder;

    localparam logic HS_ACT = 1'b0;
    localparam int   LOCK   = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       PixelClock;
    logic       hsync;
    logic [9:0] SynchPulse, BackPorch, ActiveVideo, FrontPorch;
    logic [9:0] xposition;
    logic       ActiveFlag, LineStart, Locked, TimingError;
`ifdef ERROR_COUNT_EN
    logic [7:0] ErrorCount;
`endif

    hsync_decoder #(.HSYNC_ACTIVE(HS_ACT), .LOCK_LINES(LOCK)) dut (
        .clock(clock),
        .reset(reset),
        .PixelClock(PixelClock),
        .hsync(hsync),
        .SynchPulse(SynchPulse),
        .BackPorch(BackPorch),
        .ActiveVideo(ActiveVideo),
        .FrontPorch(FrontPorch),
        .xposition(xposition),
        .ActiveFlag(ActiveFlag),
        .LineStart(LineStart),
        .Locked(Locked),
`ifdef ERROR_COUNT_EN
        .ErrorCount(ErrorCount),
`endif
        .TimingError(TimingError)
    );

    always #1 clock = ~clock;

    typedef struct {
        int lineStart;
        int timingError;
        int activeFlag;
        int xpos;
        int locked;
        int errCnt;
    } exp_t;

    exp_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference model state
    logic mPcPrev;
    logic mPrevA;
    bit   mSynced;
    int   mPos, mGood, mFlag, mX, mLocked, mErrCnt;

    function automatic int eff(input logic [9:0] v);
        return (v == 10'd0) ? 1 : int'(v);
    endfunction

    task automatic modelReset();
        mPcPrev = 1'b1; mPrevA = 1'b1; mSynced = 0;
        mPos = 0; mGood = 0; mFlag = 0; mX = 0; mLocked = 0; mErrCnt = 0;
    endtask

    task automatic modelStep(input logic pc, input logic hs, input logic rst, output exp_t e);
        int  s, b, v, f, t, p;
        bit  a, ls, te;
        ls = 0; te = 0;
        if (rst) begin
            modelReset();
        end else begin
            if (pc && !mPcPrev) begin
                s = eff(SynchPulse); b = eff(BackPorch); v = eff(ActiveVideo); f = eff(FrontPorch);
                t = s + b + v + f;
                a = (hs == HS_ACT);
                mFlag = 0; mX = 0;
                if (!mSynced) begin
                    if (a && !mPrevA) begin mSynced = 1; mPos = 1; ls = 1; end
                end else begin
                    p = mPos + 1;
                    if (p <= s) begin
                        if (a) mPos = p; else te = 1;
                    end else if (p == s + 1 && a) begin
                        te = 1;
                    end else if (p <= t) begin
                        if (a) begin
                            te = 1; ls = 1; mPos = 1;
                        end else begin
                            mPos = p;
                            if (p > s + b && p <= s + b + v) begin mFlag = 1; mX = p - s - b - 1; end
                        end
                    end else begin
                        if (a) begin
                            ls = 1; mPos = 1;
                            if (mGood < 15) mGood++;
                        end else te = 1;
                    end
                    if (te && !ls) mSynced = 0;
                end
                if (te) begin
                    mGood = 0;
                    if (mErrCnt < 255) mErrCnt++;
                end
                mPrevA = a;
                mLocked = (mGood >= LOCK) ? 1 : 0;
            end
            mPcPrev = pc;
        end
        e.lineStart = ls; e.timingError = te; e.activeFlag = mFlag;
        e.xpos = mX; e.locked = mLocked; e.errCnt = mErrCnt;
    endtask

    // Drive one clock cycle of inputs and queue the response expected after the next edge
    task automatic applyStimulus(input logic pc, input logic hs, input logic rst);
        exp_t e;
        @(negedge clock);
        PixelClock = pc; hsync = hs; reset = rst;
        modelStep(pc, hs, rst, e);
        expQ.push_back(e);
    endtask

    task automatic sendPixel(input bit asrt);
        logic lvl;
        int   hi, lo;
        lvl = asrt ? HS_ACT : ~HS_ACT;
        hi = $urandom_range(1, 2);
        lo = $urandom_range(1, 2);
        repeat (hi) applyStimulus(1'b1, lvl, 1'b0);
        repeat (lo) applyStimulus(1'b0, lvl, 1'b0);
    endtask

    task automatic sendLine(input int syncW, input int deW);
        repeat (syncW) sendPixel(1'b1);
        repeat (deW) sendPixel(1'b0);
    endtask

    task automatic checkField(input string name, input int got, input int want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkField("LineStart", int'(LineStart), e.lineStart);
        checkField("TimingError", int'(TimingError), e.timingError);
        checkField("ActiveFlag", int'(ActiveFlag), e.activeFlag);
        checkField("xposition", int'(xposition), e.xpos);
        checkField("Locked", int'(Locked), e.locked);
`ifdef ERROR_COUNT_EN
        checkField("ErrorCount", int'(ErrorCount), e.errCnt);
`endif
    endtask

    // Monitor: each cycle the DUT presents registered outputs; compare against the queued expectation
    always @(posedge clock) begin
        #0.5;
        if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r;
        reset = 1'b1; PixelClock = 1'b0; hsync = ~HS_ACT;
        SynchPulse = 10'd2; BackPorch = 10'd3; ActiveVideo = 10'd5; FrontPorch = 10'd2;
        modelReset();
        repeat (3) applyStimulus(1'b0, ~HS_ACT, 1'b1);

        $display("[TB] clean stream");
        repeat (6) sendLine(2, 10);

        $display("[TB] short sync");
        sendLine(1, 10);
        repeat (4) sendLine(2, 10);

        $display("[TB] early sync at xposition 2");
        sendLine(2, 5);
        repeat (4) sendLine(2, 10);

        $display("[TB] long front porch");
        sendLine(2, 11);
        repeat (4) sendLine(2, 10);

        $display("[TB] reset mid-active with PixelClock high");
        sendLine(2, 4);
        applyStimulus(1'b1, ~HS_ACT, 1'b0);
        applyStimulus(1'b1, ~HS_ACT, 1'b1);
        repeat (3) applyStimulus(1'b1, ~HS_ACT, 1'b0);
        applyStimulus(1'b0, ~HS_ACT, 1'b0);
        repeat (5) sendLine(2, 10);

        $display("[TB] randomized line faults");
        repeat (60) begin
            r = $urandom_range(0, 11);
            case (r)
                0: sendLine(1, 10);
                1: sendLine(3, 10);
                2: sendLine(2, $urandom_range(1, 9));
                3: sendLine(2, 11);
                4: begin
                    repeat ($urandom_range(1, 6)) sendPixel($urandom_range(0, 1) == 1);
                    applyStimulus(1'($urandom_range(0, 1)), ~HS_ACT, 1'b1);
                    applyStimulus(1'b0, ~HS_ACT, 1'b0);
                end
                default: sendLine(2, 10);
            endcase
        end

        $display("[TB] zero timing fields (treated as one)");
        applyStimulus(1'b0, ~HS_ACT, 1'b1);
        SynchPulse = 10'd0; BackPorch = 10'd1; ActiveVideo = 10'd3; FrontPorch = 10'd0;
        applyStimulus(1'b0, ~HS_ACT, 1'b0);
        repeat (20) begin
            r = $urandom_range(0, 7);
            case (r)
                0: sendLine(2, 5);
                1: sendLine(1, $urandom_range(1, 6));
                default: sendLine(1, 5);
            endcase
        end

        $display("[TB] repeated short-sync errors");
        applyStimulus(1'b0, ~HS_ACT, 1'b1);
        SynchPulse = 10'd2; BackPorch = 10'd3; ActiveVideo = 10'd5; FrontPorch = 10'd2;
        applyStimulus(1'b0, ~HS_ACT, 1'b0);
        repeat (310) sendLine(1, 1);
        repeat (4) applyStimulus(1'b0, ~HS_ACT, 1'b0);
        applyStimulus(1'b0, ~HS_ACT, 1'b1);
        repeat (4) applyStimulus(1'b0, ~HS_ACT, 1'b0);

        repeat (4) @(posedge clock);
        #1;
        checkField("queue drained", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
